mul_sequencer: RTL and testbench
================================

MUL_SEQUENCER -- requirements
Module: mul_sequencer

Interface
REQ-001 SHALL have port iClk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port iRst, input, 1 bit, synchronous, active-high reset.
REQ-003 SHALL have port iStart, input, 1 bit, request to start a multiply; sampled only in IDLE.
REQ-004 SHALL have ports iMulA and iMulB, inputs, 32 bits each, the unsigned multiplicand and multiplier, captured on the accepted start.
REQ-005 SHALL have port oBusy, output, 1 bit, high in states LOAD, ADD, CARRY and SHIFT.
REQ-006 SHALL have port oDone, output, 1 bit, a one-cycle pulse in state DONE.
REQ-007 SHALL have ports oProdHi and oProdLo, outputs, 32 bits each, the 64-bit unsigned product.
REQ-008 SHALL have ports oAluA and oAluB (32 bits each) and oAluOp (4 bits), outputs driving the shared ALU operands and opcode.
REQ-009 SHALL have port oAluReq, output, 1 bit, high when the sequencer owns the shared ALU.
REQ-010 SHALL have port iAluData, input, 32 bits, the shared ALU result, combinational in the same cycle.

Function
REQ-011 SHALL implement the FSM states IDLE, LOAD, ADD, CARRY, SHIFT and DONE.
REQ-012 SHALL hold the registers mcand[31:0], hi[31:0], lo[31:0], sum[31:0], carry (1 bit) and cnt (32-bit one-hot).
REQ-013 SHALL, in IDLE with iStart=1, capture mcand=iMulA and lo=iMulB and go to LOAD; with iStart=0 it SHALL stay in IDLE.
REQ-014 SHALL, in LOAD, set hi=0, carry=0 and cnt=32'h1, then go to ADD if lo[0]=1, else to SHIFT.
REQ-015 SHALL, in ADD, drive oAluA=hi, oAluB=mcand and oAluOp=ADD (4'b0000), latch sum=iAluData, and go to CARRY.
REQ-016 SHALL, in CARRY, drive oAluA=sum, oAluB=hi and oAluOp=SLTU (4'b0011), latch carry=iAluData[0] and hi=sum, and go to SHIFT.
REQ-017 SHALL, in SHIFT, load {carry,hi,lo} with {1'b0,carry,hi,lo[31:1]}, using wiring only, and rotate cnt left by one.
REQ-018 SHALL, in SHIFT, go to DONE if cnt[31]=1 before the rotate; otherwise it SHALL go to ADD if the new lo[0]=1, else to SHIFT.
REQ-019 SHALL, in DONE, assert oDone for one cycle and return to IDLE.
REQ-020 SHALL make oProdHi=hi and oProdLo=lo, held stable from DONE until the next accepted start.
REQ-021 SHALL assert oAluReq only in ADD and CARRY.
REQ-022 SHALL drive oAluA=0, oAluB=0 and oAluOp=4'b0000 in every other state.
REQ-023 SHALL assert oDone in cycle 33+2*popcount(iMulB) after the start edge; the bounds are 33 and 97.
REQ-024 SHALL ignore iStart when not in IDLE, including in DONE.
REQ-025 SHALL contain no adders or shift operators in the RTL; all arithmetic goes through the shared ALU.
REQ-026 SHALL produce the exact carry-out, including when mcand=0 (SLTU then yields 0).

Reset
REQ-027 SHALL, on iRst=1 at any edge, including mid-operation, enter IDLE and clear every register to 0.
REQ-028 SHALL, while in reset, drive oBusy=0, oDone=0, oProdHi=0, oProdLo=0, oAluReq=0, oAluA=0, oAluB=0 and oAluOp=0.
REQ-029 SHALL take iRst precedence over iStart in the same cycle.

Structure
REQ-030 SHALL take the ALU opcode constants ADD=4'b0000, SUB=4'b1000, SLL=4'b0001, SRL=4'b1001, SRA=4'b1101, SLT=4'b0010, SLTU=4'b0011, XOR=4'b0100, OR=4'b0110 and AND=4'b0111, plus the FSM state encoding, from a shared ALU package.
REQ-031 SHALL instantiate no sub-module; the ALU and the mux that arbitrates it via oAluReq sit at the parent level.

Verification
REQ-032 SHALL cover: A=3, B=5 -> oDone at cycle 37, oProdHi=0, oProdLo=15.
REQ-033 SHALL cover: A=32'hFFFFFFFF, B=32'hFFFFFFFF -> oDone at cycle 97, oProdHi=32'hFFFFFFFE, oProdLo=32'h00000001 (exercises the carry path).
REQ-034 SHALL cover: A=32'h80000000, B=2 -> oProdHi=1, oProdLo=0; A=7, B=0 -> oDone at cycle 33, with oAluReq never high and the product 0.
REQ-035 SHALL cover: iStart pulsed at cycles 5 and 20 of a busy operation -> both ignored, a single oDone, and a correct product.
REQ-036 SHALL cover: iRst asserted at cycle 10 of an operation -> next cycle IDLE with all outputs 0, then a fresh start A=6, B=7 -> oProdLo=42.

Source files
------------

// File: rtl/mul_sequencer_pkg.sv
// Shared ALU package: opcode constants for the shared ALU and the state
// encoding of the multiply sequencer FSM.
package mul_sequencer_pkg;

  localparam logic [3:0] AluAdd  = 4'b0000;
  localparam logic [3:0] AluSub  = 4'b1000;
  localparam logic [3:0] AluSll  = 4'b0001;
  localparam logic [3:0] AluSrl  = 4'b1001;
  localparam logic [3:0] AluSra  = 4'b1101;
  localparam logic [3:0] AluSlt  = 4'b0010;
  localparam logic [3:0] AluSltu = 4'b0011;
  localparam logic [3:0] AluXor  = 4'b0100;
  localparam logic [3:0] AluOr   = 4'b0110;
  localparam logic [3:0] AluAnd  = 4'b0111;

  // StIdle must stay at encoding 0 so a cleared state register means IDLE.
  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoad  = 3'd1,
    StAdd   = 3'd2,
    StCarry = 3'd3,
    StShift = 3'd4,
    StDone  = 3'd5
  } mul_state_e;

endpackage

// File: rtl/mul_sequencer_if.sv
// Multiply sequencer bus: start/operand request, status and product, and the
// shared ALU operand/result path.
//   slave  : seen by the sequencer (requests and ALU result in, status/product/ALU operands out)
//   master : seen by the requester/parent (drives requests and ALU result)
interface mul_sequencer_if;

  logic        iStart;
  logic [31:0] iMulA;
  logic [31:0] iMulB;
  logic        oBusy;
  logic        oDone;
  logic [31:0] oProdHi;
  logic [31:0] oProdLo;
  logic [31:0] oAluA;
  logic [31:0] oAluB;
  logic [3:0]  oAluOp;
  logic        oAluReq;
  logic [31:0] iAluData;

  modport slave (
    input  iStart, iMulA, iMulB, iAluData,
    output oBusy, oDone, oProdHi, oProdLo, oAluA, oAluB, oAluOp, oAluReq
  );

  modport master (
    output iStart, iMulA, iMulB, iAluData,
    input  oBusy, oDone, oProdHi, oProdLo, oAluA, oAluB, oAluOp, oAluReq
  );

endinterface

// File: rtl/mul_sequencer.sv
// 32x32 unsigned shift-and-add multiplier that borrows a shared ALU for every
// addition (ADD for the partial sum, SLTU to recover the carry-out).
// Ports:
//   iClk  : clock, rising edge
//   iRst  : synchronous active-high reset
//   bus   : mul_sequencer_if.slave - start/operands in, busy/done/product out,
//           ALU operands/opcode/request out, ALU result in (combinational)
module mul_sequencer
  import mul_sequencer_pkg::*;
(
  input  logic            iClk,
  input  logic            iRst,
  mul_sequencer_if.slave  bus
);

  mul_state_e  state_q, state_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] sum_q, sum_d;
  logic        carry_q, carry_d;
  logic [31:0] cnt_q, cnt_d;

  // Registered outputs, computed from the next state.
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        alu_req_q, alu_req_d;
  logic [31:0] alu_a_q, alu_a_d;
  logic [31:0] alu_b_q, alu_b_d;
  logic [3:0]  alu_op_q, alu_op_d;

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (bus.iStart) begin
          mcand_d = bus.iMulA;
          lo_d    = bus.iMulB;
          state_d = StLoad;
        end
      end
      StLoad: begin
        hi_d    = '0;
        carry_d = 1'b0;
        cnt_d   = 32'h1;
        state_d = lo_q[0] ? StAdd : StShift;
      end
      StAdd: begin
        sum_d   = bus.iAluData;
        state_d = StCarry;
      end
      StCarry: begin
        // sum < hi (unsigned) exactly when hi + mcand overflowed.
        carry_d = bus.iAluData[0];
        hi_d    = sum_q;
        state_d = StShift;
      end
      StShift: begin
        // 65-bit right shift of {carry,hi,lo} done purely by wiring.
        {carry_d, hi_d, lo_d} = {1'b0, carry_q, hi_q, lo_q[31:1]};
        cnt_d = {cnt_q[30:0], cnt_q[31]};
        if (cnt_q[31]) begin
          state_d = StDone;
        end else if (lo_q[1]) begin
          state_d = StAdd;
        end else begin
          state_d = StShift;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d    = state_d inside {StLoad, StAdd, StCarry, StShift};
    done_d    = (state_d == StDone);
    alu_req_d = state_d inside {StAdd, StCarry};
    alu_a_d   = '0;
    alu_b_d   = '0;
    alu_op_d  = AluAdd;
    if (state_d == StAdd) begin
      alu_a_d = hi_d;
      alu_b_d = mcand_d;
    end else if (state_d == StCarry) begin
      alu_a_d  = sum_d;
      alu_b_d  = hi_d;
      alu_op_d = AluSltu;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q   <= StIdle;
      mcand_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      sum_q     <= '0;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      alu_req_q <= 1'b0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_op_q  <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      sum_q     <= sum_d;
      carry_q   <= carry_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      alu_req_q <= alu_req_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_op_q  <= alu_op_d;
    end
  end

  assign bus.oBusy   = busy_q;
  assign bus.oDone   = done_q;
  assign bus.oProdHi = hi_q;
  assign bus.oProdLo = lo_q;
  assign bus.oAluReq = alu_req_q;
  assign bus.oAluA   = alu_a_q;
  assign bus.oAluB   = alu_b_q;
  assign bus.oAluOp  = alu_op_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed bench for mul_sequencer with a parent-level ALU model and a
// scoreboard of expected products and done latencies.
module tb_mul_sequencer;
  import mul_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mul_sequencer_if bus ();

  mul_sequencer dut (
    .iClk (clk),
    .iRst (rst),
    .bus  (bus)
  );

  // Shared ALU with request mux at the parent level.
  logic [31:0] alu_a, alu_b, alu_y;
  logic [3:0]  alu_op;
  always_comb begin
    alu_a  = bus.oAluReq ? bus.oAluA : 32'h0;
    alu_b  = bus.oAluReq ? bus.oAluB : 32'h0;
    alu_op = bus.oAluReq ? bus.oAluOp : AluAdd;
    alu_y  = 32'h0;
    case (alu_op)
      AluAdd:  alu_y = alu_a + alu_b;
      AluSub:  alu_y = alu_a - alu_b;
      AluSltu: alu_y = {31'h0, alu_a < alu_b};
      AluXor:  alu_y = alu_a ^ alu_b;
      AluOr:   alu_y = alu_a | alu_b;
      AluAnd:  alu_y = alu_a & alu_b;
      default: alu_y = 32'h0;
    endcase
  end
  assign bus.iAluData = alu_y;

  typedef struct {
    logic [63:0] prod;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  bit   saw_req;
  exp_t dropped;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    @(negedge clk);
    bus.iStart = 1'b1;
    bus.iMulA  = a;
    bus.iMulB  = b;
    e.prod = 64'(a) * 64'(b);
    e.lat  = 33 + 2 * $countones(b);
    sb.push_back(e);
    @(negedge clk);
    bus.iStart = 1'b0;
  endtask

  // Waits for oDone (cycle 0 = just after the start edge), optionally pulsing
  // iStart at cycles p1/p2 and in the DONE cycle, then scores the result.
  task automatic finish_op(input string tag, input int p1, input int p2, input bit poke_done,
                           output bit req_seen);
    int   cyc;
    bit   got;
    int   dones;
    exp_t e;
    cyc = 0; got = 1'b0; req_seen = 1'b0; dones = 0;
    while (!got && cyc < 200) begin
      @(negedge clk);
      cyc++;
      bus.iStart = (cyc == p1) || (cyc == p2);
      if (bus.iStart) begin
        bus.iMulA = $urandom;
        bus.iMulB = $urandom;
      end
      if (bus.oAluReq) req_seen = 1'b1;
      if (bus.oDone) got = 1'b1;
    end
    e = sb.pop_front();
    chk({tag, "_done_seen"}, 64'(got), 64'd1);
    chk({tag, "_latency"}, 64'(cyc), 64'(e.lat));
    chk({tag, "_product"}, {bus.oProdHi, bus.oProdLo}, e.prod);
    chk({tag, "_busy_in_done"}, 64'(bus.oBusy), 64'd0);
    if (poke_done) begin
      bus.iStart = 1'b1;
      bus.iMulA  = 32'h1234;
      bus.iMulB  = 32'hFFFF;
    end
    @(negedge clk);
    bus.iStart = 1'b0;
    chk({tag, "_done_pulse"}, 64'(bus.oDone), 64'd0);
    chk({tag, "_idle_after"}, 64'(bus.oBusy), 64'd0);
    chk({tag, "_hold"}, {bus.oProdHi, bus.oProdLo}, e.prod);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 64'(bus.oBusy), 64'd0);
    chk({tag, "_done"}, 64'(bus.oDone), 64'd0);
    chk({tag, "_prod"}, {bus.oProdHi, bus.oProdLo}, 64'd0);
    chk({tag, "_alureq"}, 64'(bus.oAluReq), 64'd0);
    chk({tag, "_alu_ab"}, {bus.oAluA, bus.oAluB}, 64'd0);
    chk({tag, "_aluop"}, 64'(bus.oAluOp), 64'd0);
  endtask

  initial begin
    rst        = 1'b1;
    bus.iStart = 1'b0;
    bus.iMulA  = '0;
    bus.iMulB  = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");

    // Reset wins over a simultaneous start.
    bus.iStart = 1'b1;
    bus.iMulA  = 32'd9;
    bus.iMulB  = 32'd9;
    @(negedge clk);
    rst        = 1'b0;
    bus.iStart = 1'b0;
    @(negedge clk);
    chk("rst_over_start_busy", 64'(bus.oBusy), 64'd0);

    start_op(32'd3, 32'd5);
    finish_op("a3b5", -1, -1, 1'b0, saw_req);

    start_op(32'hFFFFFFFF, 32'hFFFFFFFF);
    finish_op("all_ones", -1, -1, 1'b0, saw_req);

    start_op(32'h80000000, 32'd2);
    finish_op("msb_x2", -1, -1, 1'b0, saw_req);

    start_op(32'd7, 32'd0);
    finish_op("b_zero", -1, -1, 1'b0, saw_req);
    chk("b_zero_no_alureq", 64'(saw_req), 64'd0);

    start_op(32'd0, 32'hA5A5A5A5);
    finish_op("a_zero", -1, -1, 1'b0, saw_req);

    // Start pulses while busy and in DONE must be ignored.
    start_op(32'h0001E241, 32'h00000F0F);
    finish_op("busy_pulses", 5, 20, 1'b1, saw_req);

    // Reset mid-operation, then a fresh multiply.
    start_op(32'hDEAD, 32'hBEEF);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_all_zero("mid_reset");
    rst = 1'b0;
    dropped = sb.pop_front();
    start_op(32'd6, 32'd7);
    finish_op("after_reset", -1, -1, 1'b0, saw_req);

    for (int i = 0; i < 3; i++) begin
      start_op($urandom, $urandom);
      finish_op($sformatf("rand%0d", i), -1, -1, 1'b0, saw_req);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
